// File: rtl/prbs_slicer_chk.sv
// rtl/prbs_slicer_chk.sv - receive slicer and PRBS21 (x^21+x^2+1) lock/error checker
//
// Optional feature macro: PRBS_CHK_OFFSET_EN (adds the 'offset' threshold input).
//
// Ports:
//   emu_clk    : clock
//   emu_rst_n  : asynchronous active-low reset
//   in_        : signed fixed-point lane sample
//   offset     : signed slicer threshold (only with PRBS_CHK_OFFSET_EN)
//   clk_en     : sample strobe, one bit per high cycle
//   clr        : synchronous clear of bit_cnt / err_cnt
//   bit_o      : sliced bit
//   bit_valid  : one-cycle pulse when bit_o updates
//   locked     : checker is in LOCK
//   state      : 0 = SEED, 1 = SYNC, 2 = LOCK
//   bit_cnt    : saturating count of bits checked while locked
//   err_cnt    : saturating count of errors seen while locked
module prbs_slicer_chk #(
    parameter int WIDTH     = 18,
    parameter int SYNC_BITS = 64,
    parameter int LOS_WIN   = 256,
    parameter int LOS_ERRS  = 8,
    parameter int CNT_WIDTH = 32
) (
    input  logic                        emu_clk,
    input  logic                        emu_rst_n,
    input  logic signed [WIDTH-1:0]     in_,
`ifdef PRBS_CHK_OFFSET_EN
    input  logic signed [WIDTH-1:0]     offset,
`endif
    input  logic                        clk_en,
    input  logic                        clr,
    output logic                        bit_o,
    output logic                        bit_valid,
    output logic                        locked,
    output logic [1:0]                  state,
    output logic [CNT_WIDTH-1:0]        bit_cnt,
    output logic [CNT_WIDTH-1:0]        err_cnt
);

    localparam int MW = $clog2(SYNC_BITS + 1);
    localparam int WW = $clog2(LOS_WIN + 1);
    localparam int EW = $clog2(LOS_ERRS + 1);
    localparam logic [MW-1:0] MATCH_LAST = MW'(SYNC_BITS - 1);
    localparam logic [WW-1:0] WIN_LAST   = WW'(LOS_WIN - 1);
    localparam logic [EW-1:0] ERR_LAST   = EW'(LOS_ERRS - 1);
    localparam logic [4:0]    SEED_LAST  = 5'd20;

    typedef enum logic [1:0] {
        ST_SEED = 2'd0,
        ST_SYNC = 2'd1,
        ST_LOCK = 2'd2
    } state_t;

    // ---------------- stage 1: slicer ----------------
    logic decision;

`ifdef PRBS_CHK_OFFSET_EN
    // One extra bit of headroom so max-negative minus max-positive cannot wrap.
    logic signed [WIDTH:0] diff;
    assign diff     = {in_[WIDTH-1], in_} - {offset[WIDTH-1], offset};
    assign decision = ~diff[WIDTH];
`else
    assign decision = ~in_[WIDTH-1];
`endif

    always_ff @(posedge emu_clk or negedge emu_rst_n) begin
        if (!emu_rst_n) begin
            bit_o     <= 1'b0;
            bit_valid <= 1'b0;
        end else begin
            bit_valid <= clk_en;
            if (clk_en) begin
                bit_o <= decision;
            end
        end
    end

    // ---------------- stage 2: checker ----------------
    state_t                 state_q, state_d;
    logic [20:0]            ref_q, ref_d;
    logic [4:0]             seed_q, seed_d;
    logic [MW-1:0]          match_q, match_d;
    logic [WW-1:0]          win_q, win_d;
    logic [EW-1:0]          werr_q, werr_d;
    logic [CNT_WIDTH-1:0]   bit_cnt_d, err_cnt_d;
    logic                   pred;
    logic                   bit_inc;
    logic                   bit_err;

    assign pred = ref_q[20] ^ ref_q[1];

    always_comb begin
        state_d = state_q;
        ref_d   = ref_q;
        seed_d  = seed_q;
        match_d = match_q;
        win_d   = win_q;
        werr_d  = werr_q;
        bit_inc = 1'b0;
        bit_err = 1'b0;

        if (bit_valid) begin
            case (state_q)
                ST_SEED: begin
                    ref_d = {ref_q[19:0], bit_o};
                    if (seed_q == SEED_LAST) begin
                        seed_d  = 5'd0;
                        match_d = '0;
                        state_d = ST_SYNC;
                    end else begin
                        seed_d = seed_q + 5'd1;
                    end
                end
                ST_SYNC: begin
                    // An all-zero reference is the LFSR lock-up state and
                    // would "predict" a constant-zero input forever.
                    if ((ref_q != 21'd0) && (bit_o == pred)) begin
                        ref_d   = {ref_q[19:0], bit_o};
                        match_d = match_q + 1'b1;
                        if (match_q == MATCH_LAST) begin
                            state_d = ST_LOCK;
                            win_d   = '0;
                            werr_d  = '0;
                        end
                    end else begin
                        // Bit is dropped; seeding restarts with the next one.
                        state_d = ST_SEED;
                        seed_d  = 5'd0;
                    end
                end
                ST_LOCK: begin
                    // Free-running reference: a corrupted bit never enters
                    // ref, so one flipped bit costs exactly one error.
                    ref_d   = {ref_q[19:0], pred};
                    bit_inc = 1'b1;
                    bit_err = (bit_o != pred);
                    if (bit_err && (werr_q == ERR_LAST)) begin
                        state_d = ST_SEED;
                        seed_d  = 5'd0;
                    end else if (win_q == WIN_LAST) begin
                        win_d  = '0;
                        werr_d = '0;
                    end else begin
                        win_d = win_q + 1'b1;
                        if (bit_err) begin
                            werr_d = werr_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_SEED;
                    seed_d  = 5'd0;
                end
            endcase
        end

        // Counters saturate; clr takes priority over a same-cycle increment.
        bit_cnt_d = bit_cnt;
        err_cnt_d = err_cnt;
        if (clr) begin
            bit_cnt_d = '0;
            err_cnt_d = '0;
        end else begin
            if (bit_inc && (bit_cnt != {CNT_WIDTH{1'b1}})) begin
                bit_cnt_d = bit_cnt + 1'b1;
            end
            if (bit_err && (err_cnt != {CNT_WIDTH{1'b1}})) begin
                err_cnt_d = err_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge emu_clk or negedge emu_rst_n) begin
        if (!emu_rst_n) begin
            state_q <= ST_SEED;
            ref_q   <= 21'd0;
            seed_q  <= 5'd0;
            match_q <= '0;
            win_q   <= '0;
            werr_q  <= '0;
            bit_cnt <= '0;
            err_cnt <= '0;
        end else begin
            state_q <= state_d;
            ref_q   <= ref_d;
            seed_q  <= seed_d;
            match_q <= match_d;
            win_q   <= win_d;
            werr_q  <= werr_d;
            bit_cnt <= bit_cnt_d;
            err_cnt <= err_cnt_d;
        end
    end

    assign state  = state_q;
    assign locked = (state_q == ST_LOCK);

endmodule

// File: tb/tb_prbs_slicer_chk.sv
// tb/tb_prbs_slicer_chk.sv - self-checking bench for prbs_slicer_chk
module tb_prbs_slicer_chk;

    logic               emu_clk;
    logic               emu_rst_n;
    logic signed [17:0] in_;
    logic               clk_en;
    logic               clr;
`ifdef PRBS_CHK_OFFSET_EN
    logic signed [17:0] offset;
`endif

    logic        bit_o, bit_valid, locked;
    logic [1:0]  state;
    logic [31:0] bit_cnt, err_cnt;

    logic        s_bit_o, s_bit_valid, s_locked;
    logic [1:0]  s_state;
    logic [3:0]  s_bit_cnt, s_err_cnt;

    int total = 0;
    int bad   = 0;

    logic [20:0] sr;

    prbs_slicer_chk u_dut (
        .emu_clk   (emu_clk),
        .emu_rst_n (emu_rst_n),
        .in_       (in_),
`ifdef PRBS_CHK_OFFSET_EN
        .offset    (offset),
`endif
        .clk_en    (clk_en),
        .clr       (clr),
        .bit_o     (bit_o),
        .bit_valid (bit_valid),
        .locked    (locked),
        .state     (state),
        .bit_cnt   (bit_cnt),
        .err_cnt   (err_cnt)
    );

    prbs_slicer_chk #(.CNT_WIDTH(4)) u_sat (
        .emu_clk   (emu_clk),
        .emu_rst_n (emu_rst_n),
        .in_       (in_),
`ifdef PRBS_CHK_OFFSET_EN
        .offset    (offset),
`endif
        .clk_en    (clk_en),
        .clr       (clr),
        .bit_o     (s_bit_o),
        .bit_valid (s_bit_valid),
        .locked    (s_locked),
        .state     (s_state),
        .bit_cnt   (s_bit_cnt),
        .err_cnt   (s_err_cnt)
    );

    initial emu_clk = 1'b0;
    always #5 emu_clk = ~emu_clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // TX PRBS21 reference: sr[0] <= sr[20] ^ sr[1], transmitted bit is the new one.
    function automatic logic next_prbs();
        logic nb;
        nb = sr[20] ^ sr[1];
        sr = {sr[19:0], nb};
        return nb;
    endfunction

    // Random-amplitude analog value whose sign encodes the bit (0 counts as 1).
    function automatic logic signed [17:0] amp(input logic b);
        int v;
        if (b) v = int'($urandom_range(0, 131071));
        else   v = -int'($urandom_range(1, 131072));
        return v[17:0];
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge emu_clk);
            #1;
        end
    endtask

    // Drives one strobe; returns one cycle after the strobe edge.
    task automatic strobe(input logic b);
        in_    = amp(b);
        clk_en = 1'b1;
        @(posedge emu_clk);
        #1;
        clk_en = 1'b0;
    endtask

    task automatic send(input logic b, input int gap);
        strobe(b);
        idle(gap - 1);
    endtask

    // 84 clean bits must not lock; the 85th locks exactly two cycles after its strobe.
    task automatic lock_85(input string tag);
        logic early;
        early = 1'b0;
        for (int i = 0; i < 84; i++) begin
            send(next_prbs(), int'($urandom_range(1, 4)));
            if (locked) early = 1'b1;
        end
        check({tag, "_no_early_lock"}, 64'(early), 64'd0);
        strobe(next_prbs());
        check({tag, "_locked_n+1"}, 64'(locked), 64'd0);
        idle(1);
        check({tag, "_locked_n+2"}, 64'(locked), 64'd1);
        check({tag, "_state_lock"}, 64'(state), 64'd2);
    endtask

    initial begin
        int  sync_entries;
        logic [1:0] prev_state;
        logic saw_lock;
        logic b;

        emu_rst_n = 1'b0;
        in_       = '0;
        clk_en    = 1'b0;
        clr       = 1'b0;
`ifdef PRBS_CHK_OFFSET_EN
        offset    = '0;
`endif
        sr = 21'($urandom_range(1, 2097151));

        idle(3);
        check("rst_state",     64'(state),     64'd0);
        check("rst_locked",    64'(locked),    64'd0);
        check("rst_bit_valid", 64'(bit_valid), 64'd0);
        check("rst_bit_o",     64'(bit_o),     64'd0);
        check("rst_bit_cnt",   64'(bit_cnt),   64'd0);
        check("rst_err_cnt",   64'(err_cnt),   64'd0);
        emu_rst_n = 1'b1;
        idle(2);

        // Slicer latency: bit_valid/bit_o one cycle after the strobe.
        strobe(1'b1);
        check("slice_valid_pulse", 64'(bit_valid), 64'd1);
        check("slice_bit_one",     64'(bit_o),     64'd1);
        idle(1);
        check("slice_valid_drop",  64'(bit_valid), 64'd0);
        check("slice_bit_hold",    64'(bit_o),     64'd1);
        emu_rst_n = 1'b0;
        idle(1);
        emu_rst_n = 1'b1;
        idle(1);

        // Clean PRBS acquisition.
        lock_85("acq");

        // 1000 locked bits, random amplitudes and strobe spacing.
        for (int i = 0; i < 1000; i++) send(next_prbs(), int'($urandom_range(1, 4)));
        idle(2);
        check("clean_bit_cnt", 64'(bit_cnt),   64'd1000);
        check("clean_err_cnt", 64'(err_cnt),   64'd0);
        check("sat_bit_cnt",   64'(s_bit_cnt), 64'd15);
        check("sat_locked",    64'(s_locked),  64'd1);

        // Single flipped bit: one error, lock retained.
        b = next_prbs();
        send(~b, 1);
        idle(2);
        check("flip1_err_cnt", 64'(err_cnt), 64'd1);
        check("flip1_locked",  64'(locked),  64'd1);

        // Finish the current 256-bit window (bits 1002..1024).
        for (int i = 0; i < 23; i++) send(next_prbs(), int'($urandom_range(1, 4)));
        idle(2);
        check("win_bit_cnt", 64'(bit_cnt), 64'd1024);

        // Eight flips in the fresh window: lock drops on the 8th.
        for (int k = 0; k < 7; k++) begin
            b = next_prbs();
            send(~b, int'($urandom_range(1, 4)));
            for (int i = 0; i < 5; i++) send(next_prbs(), int'($urandom_range(1, 4)));
        end
        check("burst_locked_before8", 64'(locked), 64'd1);
        b = next_prbs();
        strobe(~b);
        check("burst_locked_n+1", 64'(locked), 64'd1);
        idle(1);
        check("burst_locked_n+2", 64'(locked),  64'd0);
        check("burst_state_seed", 64'(state),   64'd0);
        check("burst_err_cnt",    64'(err_cnt), 64'd9);
        check("burst_bit_cnt",    64'(bit_cnt), 64'd1067);

        // Relock after 85 clean bits; counters retained across the loss.
        lock_85("relock");
        check("relock_bit_cnt", 64'(bit_cnt), 64'd1067);
        check("relock_err_cnt", 64'(err_cnt), 64'd9);

        // clr on the same cycle the error would be counted: clr wins.
        b = next_prbs();
        strobe(~b);
        clr = 1'b1;
        @(posedge emu_clk);
        #1;
        clr = 1'b0;
        check("clr_err_cnt", 64'(err_cnt), 64'd0);
        check("clr_bit_cnt", 64'(bit_cnt), 64'd0);
        check("clr_locked",  64'(locked),  64'd1);
        b = next_prbs();
        send(~b, 1);
        idle(2);
        check("post_clr_err_cnt", 64'(err_cnt), 64'd1);
        check("post_clr_bit_cnt", 64'(bit_cnt), 64'd1);

        // Asynchronous reset mid-LOCK, checked before any clock edge.
        for (int i = 0; i < 5; i++) send(next_prbs(), 1);
        @(posedge emu_clk);
        #2;
        emu_rst_n = 1'b0;
        #1;
        check("async_state",   64'(state),   64'd0);
        check("async_locked",  64'(locked),  64'd0);
        check("async_bit_cnt", 64'(bit_cnt), 64'd0);
        check("async_err_cnt", 64'(err_cnt), 64'd0);
        check("async_bit_o",   64'(bit_o),   64'd0);
        @(posedge emu_clk);
        #1;
        emu_rst_n = 1'b1;
        idle(1);

        // Constant -0.5: 21 seed bits + 1 rejected bit per round -> 22 SYNC entries in 500 bits.
        sync_entries = 0;
        saw_lock     = 1'b0;
        prev_state   = state;
        for (int i = 0; i < 500; i++) begin
            in_    = -18'sd32768;
            clk_en = 1'b1;
            for (int c = 0; c < 2; c++) begin
                @(posedge emu_clk);
                #1;
                clk_en = 1'b0;
                if (locked || state == 2'd2) saw_lock = 1'b1;
                if (state == 2'd1 && prev_state != 2'd1) sync_entries++;
                prev_state = state;
            end
        end
        idle(2);
        check("const_never_locked", 64'(saw_lock),     64'd0);
        check("const_sync_entries", 64'(sync_entries), 64'd22);
        check("const_final_state",  64'(state),        64'd0);
        check("const_bit_cnt",      64'(bit_cnt),      64'd0);

`ifdef PRBS_CHK_OFFSET_EN
        offset = 18'sd16384;
        in_    = 18'sd13107;
        clk_en = 1'b1;
        idle(1);
        clk_en = 1'b0;
        check("ofs_below", 64'(bit_o), 64'd0);
        in_    = 18'sd19661;
        clk_en = 1'b1;
        idle(1);
        clk_en = 1'b0;
        check("ofs_above", 64'(bit_o), 64'd1);
        offset = 18'sd131071;
        in_    = -18'sd131072;
        clk_en = 1'b1;
        idle(1);
        clk_en = 1'b0;
        check("ofs_extreme", 64'(bit_o), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prbs_slicer_chk.md
# prbs_slicer_chk

Receive-side slicer and PRBS21 error checker that sits directly downstream of the last AFE nonlinearity stage (`nl3_o_k`). On each oscillator tick (`clk_en`), it slices one real-valued fixed-point lane to a bit. It self-synchronizes to the x^21+x^2+1 sequence produced by the TX PRBS, then counts checked bits and bit errors, and raises loss-of-lock on error bursts. One instance is used per AFE lane.

## Interface
- Clocking and reset: single clock `emu_clk`. Reset `emu_rst_n` is asynchronous and active-low.
- Parameters:
  - `WIDTH`, default 18: width of the svreal fixed-point input; the exponent is irrelevant because only sign and compare are used.
  - `SYNC_BITS`, default 64: consecutive correct predictions required to declare lock.
  - `LOS_WIN`, default 256: loss-of-signal window, in checked bits.
  - `LOS_ERRS`, default 8: number of errors within one window that drops lock.
  - `CNT_WIDTH`, default 32: width of `bit_cnt` and `err_cnt`.
- Ports:
  - `emu_clk` in 1: emulator clock.
  - `emu_rst_n` in 1: asynchronous active-low reset.
  - `in_` in `WIDTH`, signed: lane value, e.g. `nl3_o_0`.
  - `clk_en` in 1: sample strobe from `osc`, one bit per high cycle.
  - `clr` in 1: synchronous clear of `bit_cnt` and `err_cnt`.
  - `bit_o` out 1: sliced bit.
  - `bit_valid` out 1: one-cycle pulse when `bit_o` is updated.
  - `locked` out 1: checker is in the LOCK state.
  - `state` out 2: 0 = SEED, 1 = SYNC, 2 = LOCK.
  - `bit_cnt` out `CNT_WIDTH`: bits checked while locked; saturating.
  - `err_cnt` out `CNT_WIDTH`: errors seen while locked; saturating.

## Operation
- **Slicer, stage 1**
  - On `clk_en=1`: `bit_o <= (in_ >= threshold)` and `bit_valid <= 1`.
  - Otherwise `bit_valid <= 0` and `bit_o` holds.
  - Threshold is 0 by default, so the decision is `~in_[WIDTH-1]`.
- **Checker, stage 2**
  - Advances only on cycles where `bit_valid=1`.
  - Holds a 21-bit reference register `ref` and a prediction `p = ref[20]^ref[1]`.
- **SEED**
  - Each bit shifts in: `ref <= {ref[19:0], bit_o}` and `seed_cnt++`.
  - After the 21st bit: go to SYNC and clear `match_cnt`.
- **SYNC**
  - If `ref == 0`: treat as a mismatch.
  - If `bit_o == p` and `ref != 0`: shift in `bit_o` and `match_cnt++`.
  - On `match_cnt == SYNC_BITS`: go to LOCK and clear the window counters.
  - On a mismatch: go to SEED with `seed_cnt = 0`. The current bit is not consumed as seed.
- **LOCK**
  - `ref` shifts in `p`, not `bit_o` (free-running reference), so one flipped bit gives exactly one error.
  - Every bit: `bit_cnt++`, `win_cnt++`.
  - On `bit_o != p`: `err_cnt++`, `win_err++`.
  - If `win_err` reaches `LOS_ERRS`: go to SEED. `locked` falls; `bit_cnt` and `err_cnt` are retained.
  - When `win_cnt` reaches `LOS_WIN` without loss: clear `win_cnt` and `win_err`.
- **Counters**
  - Saturate at all-ones and never wrap.
  - `clr` zeroes `bit_cnt` and `err_cnt` only; state, `ref` and window counters are unaffected.
  - If `clr` and an error occur in the same cycle, `clr` wins: the counters read 0.
- **Mid-operation**
  - Reset in any state returns to SEED immediately.
  - `clk_en` may be high on consecutive cycles; every high cycle is one bit.

## Timing
- **Reset values** (async on `emu_rst_n=0`): `bit_o=0`, `bit_valid=0`, `locked=0`, `state=0`, `bit_cnt=0`, `err_cnt=0`, and `ref` and all internal counters 0.
- **Deassertion:** reset deassertion is synchronized to `emu_clk` upstream.
- **Slicer latency:** `clk_en` at cycle n gives `bit_o`/`bit_valid` at n+1.
- **Checker latency:** state and counters update at n+2 for the bit sampled at n.
- **Lock timing:** `locked` rises 2 cycles after the `clk_en` of the (21+`SYNC_BITS`)th error-free bit.
- **Lock-loss timing:** `locked` falls 2 cycles after the `clk_en` of the error that reaches `LOS_ERRS`.

## Configuration
- Macro: `PRBS_CHK_OFFSET_EN`.
- **Defined:**
  - Adds input port `offset` (signed `WIDTH`, same format as `in_`).
  - Decision is `in_ >= offset`, evaluated as a (`WIDTH`+1)-bit signed difference so it cannot overflow.
  - `offset` is sampled with `in_` on `clk_en`.
- **Undefined:**
  - No `offset` port.
  - Threshold is fixed at 0 and the decision is the inverted sign bit.

## Test plan
- **Reset:** assert `emu_rst_n=0` mid-LOCK. → All outputs go to their reset values in the same cycle without an `emu_clk` edge; `state=0`.
- **Clean PRBS21:** drive `in_` = +1.0/−1.0 from an `sr[0]<=sr[20]^sr[1]` reference, `clk_en` every 4th cycle, `SYNC_BITS=64`. → `locked` rises 2 cycles after the 85th strobe; after 1000 further bits, `bit_cnt=1000` and `err_cnt=0`.
- **Error handling after lock:**
  - Flip one bit. → `err_cnt=1` and `locked` stays 1.
  - Then flip 8 bits within 256. → `locked` falls on the 8th flip and `err_cnt=9`.
  - Then relock. → Relock occurs after 85 more clean bits.
- **Constant −0.5 input, 500 strobes:** → `locked` never asserts; `state` alternates SEED/SYNC via the all-zero guard.
- **Counter controls:**
  - Pulse `clr` in the same cycle as an error. → Both counters read 0.
  - With `CNT_WIDTH=4` and 20 locked bits. → `bit_cnt=15` (saturated).
- **Offset** (`PRBS_CHK_OFFSET_EN` defined):
  - `offset=+0.25` with `in_=+0.2`. → `bit_o=0`.
  - `in_=+0.3`. → `bit_o=1`.
  - Max-negative `in_` with max-positive `offset`. → `bit_o=0`, with no overflow.
